keypad_time_entry: RTL and testbench

//  Upstream stage of the microwave controller: turns the raw 10-bit one-hot keypad into
//  a 3-digit BCD cook time (M:ST:SO). Synchronises, debounces and one-hot-checks key

---
 rtl/keypad_time_entry.sv | 220 ++++++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_time_entry
//  Description : Keypad front end for the microwave controller. Synchronises
//                the raw one-hot keypad, debounces and one-hot-checks each
//                press, and shifts accepted digits in from the right
//                (calculator style) to build a 3-digit BCD cook time M:ST:SO.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CYCLES : matching synchronised samples needed to accept a press
//                      or a release (1..255)
//  Ports
//    clock        in   system clock, rising edge
//    reset        in   synchronous active-high reset, overrides everything
//    keypad[9:0]  in   raw keys, bit i = digit i, asynchronous to clock
//    clearn       in   synchronous active-low clear of the entered time
//    entry_en     in   1 = accepted presses may change the digits
//    sec_ones     out  BCD seconds-ones digit
//    sec_tens     out  BCD seconds-tens digit
//    mins         out  BCD minutes digit
//    digit_valid  out  one-cycle pulse in the cycle the digits change
//    key_err      out  one-cycle pulse on a multi-key synchronised sample
//    time_nonzero out  1 when any held digit is non-zero
// ============================================================================
module keypad_time_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       clearn,
    input  logic       entry_en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       digit_valid,
    output logic       key_err,
    output logic       time_nonzero
);

    localparam logic [7:0] C_DEB_CYCLES = DEBOUNCE_CYCLES[7:0];

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_ACCEPT   = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [9:0] r_sync1;
    logic [9:0] r_ks;
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_code;
    logic [9:0] r_pat;
    logic [3:0] r_sec_ones;
    logic [3:0] r_sec_tens;
    logic [3:0] r_mins;
    logic       r_digit_valid;
    logic       r_key_err;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic [3:0] w_code_nxt;
    logic [9:0] w_pat_nxt;
    logic       w_shift;
    logic       w_err;
    logic       w_any;
    logic       w_onehot;
    logic [3:0] w_idx;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_any     = (r_ks != 10'd0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_onehot  = w_any && ((r_ks & (r_ks - 10'd1)) == 10'd0);

    // Index of the set key; only meaningful when w_onehot is true.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_ks[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_pat_nxt   = r_pat;
        w_shift     = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_pat_nxt  = r_ks;
                    w_code_nxt = w_idx;
                    w_cnt_nxt  = 8'd1;
                    // A single sample is already enough when DEBOUNCE_CYCLES is 1.
                    w_state_nxt = (C_DEB_CYCLES <= 8'd1) ? S_ACCEPT : S_DEBOUNCE;
                end else if (w_any) begin
                    w_err       = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RELEASE;
                end
            end

            S_DEBOUNCE: begin
                if (r_ks != r_pat) begin
                    // Bounce: abandon the press without shifting.
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= C_DEB_CYCLES) begin
                        w_state_nxt = S_ACCEPT;
                    end
                end
            end

            S_ACCEPT: begin
                // entry_en is only consulted here; a press is consumed either way.
                w_shift     = entry_en;
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_RELEASE;
            end

            S_RELEASE: begin
                if (w_any) begin
                    // Any key (new or multiple) just restarts the release wait.
                    w_cnt_nxt = 8'd0;
                end else if (w_cnt_inc >= C_DEB_CYCLES) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Synchroniser (runs through clear; only reset zeroes it)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 10'd0;
            r_ks    <= 10'd0;
        end else begin
            r_sync1 <= keypad;
            r_ks    <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // FSM state, counter and digit registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_code        <= 4'd0;
            r_pat         <= 10'd0;
            r_sec_ones    <= 4'd0;
            r_sec_tens    <= 4'd0;
            r_mins        <= 4'd0;
            r_digit_valid <= 1'b0;
            r_key_err     <= 1'b0;
        end else if (!clearn) begin
            // Forcing RELEASE means a key held through the clear is ignored
            // until it has been let go.
            r_state       <= S_RELEASE;
            r_cnt         <= 8'd0;
            r_sec_ones    <= 4'd0;
            r_sec_tens    <= 4'd0;
            r_mins        <= 4'd0;
            r_digit_valid <= 1'b0;
            r_key_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_code        <= w_code_nxt;
            r_pat         <= w_pat_nxt;
            r_digit_valid <= w_shift;
            r_key_err     <= w_err;
            if (w_shift) begin
                r_mins     <= r_sec_tens;
                r_sec_tens <= r_sec_ones;
                r_sec_ones <= r_code;
            end
        end
    end

    assign sec_ones     = r_sec_ones;
    assign sec_tens     = r_sec_tens;
    assign mins         = r_mins;
    assign digit_valid  = r_digit_valid;
    assign key_err      = r_key_err;
    assign time_nonzero = (r_mins != 4'd0) || (r_sec_tens != 4'd0) || (r_sec_ones != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_time_entry
//  Description : Self-checking bench for keypad_time_entry. Expected digit
//                triples are queued when a press is driven and compared when
//                the DUT pulses digit_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_time_entry;

    localparam int C_DEB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       clearn;
    logic       entry_en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       digit_valid;
    logic       key_err;
    logic       time_nonzero;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_err   = 0;

    logic [11:0] sb_q[$];
    logic [11:0] sb_exp;
    logic [11:0] model = 12'h000;

    keypad_time_entry #(.DEBOUNCE_CYCLES(C_DEB)) dut (
        .clock       (clock),
        .reset       (reset),
        .keypad      (keypad),
        .clearn      (clearn),
        .entry_en    (entry_en),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .mins        (mins),
        .digit_valid (digit_valid),
        .key_err     (key_err),
        .time_nonzero(time_nonzero)
    );

    always #5 clock = ~clock;

    // Scoreboard consumer: every digit_valid pulse must match the oldest queued triple.
    always @(negedge clock) begin
        if (key_err === 1'b1) n_err++;
        if (digit_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_digit_valid got %h required none", {mins, sec_tens, sec_ones});
            end else begin
                sb_exp = sb_q.pop_front();
                if ({mins, sec_tens, sec_ones} !== sb_exp) begin
                    errors++;
                    $display("FAIL scoreboard_digits got %h required %h", {mins, sec_tens, sec_ones}, sb_exp);
                end
            end
        end
    end

    // Advance n falling edges, then step off the edge before driving/checking.
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic push_digit(input int d);
        model = {model[7:0], 4'(d)};
        sb_q.push_back(model);
    endtask

    task automatic press(input int d, input bit accept);
        if (accept) push_digit(d);
        keypad = 10'b1 << d;
        tick(8);
        keypad = 10'd0;
        tick(8);
    endtask

    // Long hold; returns the number of falling edges from drive to the pulse.
    task automatic press_timed(input int d, output int lat);
        push_digit(d);
        keypad = 10'b1 << d;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (digit_valid === 1'b1 && lat == 0) lat = i;
        end
        keypad = 10'd0;
        tick(8);
    endtask

    task automatic test_reset;
        reset = 1'b1; clearn = 1'b1; entry_en = 1'b1; keypad = 10'd0;
        tick(3);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000) begin
            errors++; $display("FAIL reset_digits got %h required 000", {mins, sec_tens, sec_ones});
        end
        checks++;
        if (digit_valid !== 1'b0) begin
            errors++; $display("FAIL reset_digit_valid got %b required 0", digit_valid);
        end
        checks++;
        if (key_err !== 1'b0) begin
            errors++; $display("FAIL reset_key_err got %b required 0", key_err);
        end
        checks++;
        if (time_nonzero !== 1'b0) begin
            errors++; $display("FAIL reset_time_nonzero got %b required 0", time_nonzero);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        int v0;
        int lat;
        v0 = n_valid;
        press_timed(3, lat);
        checks++;
        if (lat != 3 + C_DEB) begin
            errors++; $display("FAIL latency got %0d required %0d", lat, 3 + C_DEB);
        end
        press(5, 1);
        press(9, 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h359) begin
            errors++; $display("FAIL basic_digits got %h required 359", {mins, sec_tens, sec_ones});
        end
        checks++;
        if (n_valid - v0 != 3) begin
            errors++; $display("FAIL basic_pulses got %0d required 3", n_valid - v0);
        end
        checks++;
        if (time_nonzero !== 1'b1) begin
            errors++; $display("FAIL basic_time_nonzero got %b required 1", time_nonzero);
        end
    endtask

    task automatic test_bounce;
        int v0;
        int lat;
        v0 = n_valid;
        keypad = 10'b1 << 7;
        tick(3);
        keypad = 10'd0;
        tick(10);
        checks++;
        if (n_valid != v0) begin
            errors++; $display("FAIL bounce_pulses got %0d required 0", n_valid - v0);
        end
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h359) begin
            errors++; $display("FAIL bounce_digits got %h required 359", {mins, sec_tens, sec_ones});
        end
        // Full-latency acceptance shows the FSM settled back in IDLE.
        press_timed(7, lat);
        checks++;
        if (lat != 3 + C_DEB) begin
            errors++; $display("FAIL bounce_idle_latency got %0d required %0d", lat, 3 + C_DEB);
        end
    endtask

    task automatic test_multi;
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        keypad = 10'b0000010100;
        tick(6);
        keypad = 10'd0;
        tick(8);
        checks++;
        if (n_err - e0 != 1) begin
            errors++; $display("FAIL multi_key_err got %0d required 1", n_err - e0);
        end
        checks++;
        if (n_valid != v0) begin
            errors++; $display("FAIL multi_pulses got %0d required 0", n_valid - v0);
        end
        press(2, 1);
        checks++;
        if (sec_ones !== 4'd2) begin
            errors++; $display("FAIL multi_then_2 got %0d required 2", sec_ones);
        end
    endtask

    task automatic test_wrap;
        press(2, 1);
        press(4, 1);
        press(5, 1);
        press(1, 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h451) begin
            errors++; $display("FAIL wrap_digits got %h required 451", {mins, sec_tens, sec_ones});
        end
    endtask

    task automatic test_clear;
        int v0;
        press(1, 1);
        press(7, 1);
        checks++;
        if (sec_ones !== 4'd7) begin
            errors++; $display("FAIL clear_pre_digit got %0d required 7", sec_ones);
        end
        v0 = n_valid;
        keypad = 10'b1 << 9;
        tick(3);
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
        model = 12'h000;
        tick(10);
        keypad = 10'd0;
        tick(8);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || time_nonzero !== 1'b0) begin
            errors++; $display("FAIL clear_digits got %h nz %b required 000 nz 0",
                               {mins, sec_tens, sec_ones}, time_nonzero);
        end
        checks++;
        if (n_valid != v0) begin
            errors++; $display("FAIL clear_held_key got %0d pulses required 0", n_valid - v0);
        end
        press(9, 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h009) begin
            errors++; $display("FAIL clear_repress got %h required 009", {mins, sec_tens, sec_ones});
        end
        // Clear landing on the ACCEPT cycle wins over the shift.
        v0 = n_valid;
        keypad = 10'b1 << 6;
        tick(6);
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
        model = 12'h000;
        tick(2);
        keypad = 10'd0;
        tick(8);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || n_valid != v0) begin
            errors++; $display("FAIL clear_vs_accept got %h pulses %0d required 000 pulses 0",
                               {mins, sec_tens, sec_ones}, n_valid - v0);
        end
    endtask

    task automatic test_entry_en;
        int v0;
        v0 = n_valid;
        entry_en = 1'b0;
        press(8, 0);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || n_valid != v0) begin
            errors++; $display("FAIL entry_disabled got %h pulses %0d required 000 pulses 0",
                               {mins, sec_tens, sec_ones}, n_valid - v0);
        end
        entry_en = 1'b1;
        press(8, 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h008) begin
            errors++; $display("FAIL entry_enabled got %h required 008", {mins, sec_tens, sec_ones});
        end
        // Dropping entry_en mid-debounce consumes the press.
        v0 = n_valid;
        keypad = 10'b1 << 5;
        tick(4);
        entry_en = 1'b0;
        tick(4);
        keypad = 10'd0;
        tick(8);
        entry_en = 1'b1;
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h008 || n_valid != v0) begin
            errors++; $display("FAIL entry_drop_mid got %h pulses %0d required 008 pulses 0",
                               {mins, sec_tens, sec_ones}, n_valid - v0);
        end
        press(3, 1);
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h083) begin
            errors++; $display("FAIL entry_after_drop got %h required 083", {mins, sec_tens, sec_ones});
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        keypad = 10'b1 << 4;
        tick(4);
        reset = 1'b1;
        keypad = 10'd0;
        tick(2);
        model = 12'h000;
        checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || digit_valid !== 1'b0 ||
            key_err !== 1'b0 || time_nonzero !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs got %h dv %b ke %b nz %b required 000 0 0 0",
                               {mins, sec_tens, sec_ones}, digit_valid, key_err, time_nonzero);
        end
        reset = 1'b0;
        v0 = n_valid;
        tick(10);
        checks++;
        if (n_valid != v0) begin
            errors++; $display("FAIL reset_mid_pulse got %0d required 0", n_valid - v0);
        end
    endtask

    initial begin
        reset = 1'b1; clearn = 1'b1; entry_en = 1'b1; keypad = 10'd0;
        test_reset;
        test_basic;
        test_bounce;
        test_multi;
        test_wrap;
        test_clear;
        test_entry_en;
        test_reset_mid;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
